// File: rtl/button_input_core.sv
`default_nettype none
// ============================================================================
//  Module   : button_input_core
//  Purpose  : Debounced button input block behind a small register slot.
//             Each raw button level passes through a 2-flop synchronizer and
//             then its own debounce FSM (ZERO / WAIT1 / ONE / WAIT0) with a
//             down-counter stability window of DB_TICKS clk cycles.
//             Qualified presses (and optionally releases) are latched into
//             sticky write-1-to-clear capture registers.
//
//  Register map (addr[1:0], read data zero-extended to 32 bits):
//             00 : debounced levels          (read only)
//             01 : press capture             (write 1 to clear)
//             10 : release capture           (write 1 to clear, optional)
//             11 : reads zero
//
//  Ports    : clk      - system clock, rising edge
//             reset    - asynchronous active-high reset
//             cs       - slot select
//             read     - read strobe (no side effects)
//             write    - write strobe
//             addr     - register address, addr[1:0] decoded
//             wr_data  - write data
//             rd_data  - combinational read data
//             btn      - raw asynchronous button levels, active-high
//
//  Options  : define BUTTON_INPUT_CORE_RELEASE_CAPTURE_EN to include the
//             release-capture register at address 10.
//
//  Revision : 1.0 - initial release
// ============================================================================
module button_input_core #(
    parameter int N_BTN    = 4,
    parameter int DB_TICKS = 2000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic             read,
    input  logic             write,
    input  logic [4:0]       addr,
    input  logic [31:0]      wr_data,
    output logic [31:0]      rd_data,
    input  logic [N_BTN-1:0] btn
);

    localparam int                 c_cnt_w = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;
    localparam logic [c_cnt_w-1:0] c_load  = c_cnt_w'(DB_TICKS - 1);

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } db_state_t;

    // ------------------------------------------------------------------
    // Two-flop synchronizer for the asynchronous button levels
    // ------------------------------------------------------------------
    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // Per-button debounce FSMs
    // ------------------------------------------------------------------
    logic [N_BTN-1:0] w_level;
    logic [N_BTN-1:0] w_press_set;
    logic [N_BTN-1:0] w_rel_set;

    generate
        for (genvar i = 0; i < N_BTN; i++) begin : g_btn
            db_state_t          r_state;
            db_state_t          w_state_nxt;
            logic [c_cnt_w-1:0] r_cnt;
            logic [c_cnt_w-1:0] w_cnt_nxt;
            logic               w_press_pulse;
            logic               w_rel_pulse;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_state <= ZERO;
                    r_cnt   <= '0;
                end else begin
                    r_state <= w_state_nxt;
                    r_cnt   <= w_cnt_nxt;
                end
            end

            always_comb begin
                w_state_nxt   = r_state;
                w_cnt_nxt     = r_cnt;
                w_press_pulse = 1'b0;
                w_rel_pulse   = 1'b0;
                case (r_state)
                    ZERO: begin
                        if (r_sync2[i]) begin
                            w_state_nxt = WAIT1;
                            w_cnt_nxt   = c_load;
                        end
                    end
                    WAIT1: begin
                        if (!r_sync2[i]) begin
                            w_state_nxt = ZERO;
                        end else if (r_cnt == '0) begin
                            w_state_nxt   = ONE;
                            w_press_pulse = 1'b1;
                        end else begin
                            w_cnt_nxt = r_cnt - 1'b1;
                        end
                    end
                    ONE: begin
                        if (!r_sync2[i]) begin
                            w_state_nxt = WAIT0;
                            w_cnt_nxt   = c_load;
                        end
                    end
                    WAIT0: begin
                        if (r_sync2[i]) begin
                            w_state_nxt = ONE;
                        end else if (r_cnt == '0) begin
                            w_state_nxt = ZERO;
                            w_rel_pulse = 1'b1;
                        end else begin
                            w_cnt_nxt = r_cnt - 1'b1;
                        end
                    end
                    default: begin
                        w_state_nxt = ZERO;
                        w_cnt_nxt   = '0;
                    end
                endcase
            end

            // The level stays high while a release is still being qualified.
            assign w_level[i]     = (r_state == ONE) || (r_state == WAIT0);
            assign w_press_set[i] = w_press_pulse;
            assign w_rel_set[i]   = w_rel_pulse;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Press capture: sticky, write-1-to-clear, a new press beats a clear
    // ------------------------------------------------------------------
    logic [N_BTN-1:0] r_press;
    logic [N_BTN-1:0] w_press_clr;

    assign w_press_clr = (cs && write && (addr[1:0] == 2'b01)) ? wr_data[N_BTN-1:0] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_press <= '0;
        end else begin
            r_press <= (r_press & ~w_press_clr) | w_press_set;
        end
    end

`ifdef BUTTON_INPUT_CORE_RELEASE_CAPTURE_EN
    // ------------------------------------------------------------------
    // Release capture: same behaviour as press capture, at address 10
    // ------------------------------------------------------------------
    logic [N_BTN-1:0] r_rel;
    logic [N_BTN-1:0] w_rel_clr;

    assign w_rel_clr = (cs && write && (addr[1:0] == 2'b10)) ? wr_data[N_BTN-1:0] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rel <= '0;
        end else begin
            r_rel <= (r_rel & ~w_rel_clr) | w_rel_set;
        end
    end

    logic w_unused;
    assign w_unused = ^{read, addr[4:2], wr_data[31:N_BTN]};
`else
    logic [N_BTN-1:0] r_rel;
    assign r_rel = '0;

    // Release events have no destination in this build.
    logic w_unused;
    assign w_unused = ^{read, addr[4:2], wr_data[31:N_BTN], w_rel_set};
`endif

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        rd_data = '0;
        case (addr[1:0])
            2'b00:   rd_data[N_BTN-1:0] = w_level;
            2'b01:   rd_data[N_BTN-1:0] = r_press;
            2'b10:   rd_data[N_BTN-1:0] = r_rel;
            default: rd_data = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/button_input_core.md
BUTTON_INPUT_CORE -- requirements
Module: button_input_core

Interface
REQ-001 SHALL provide parameter N_BTN, default 4, the number of button inputs (1..16).
REQ-002 SHALL provide parameter DB_TICKS, default 2000000, the debounce stability window in clk cycles (20 ms at 100 MHz); minimum 2.
REQ-003 SHALL provide port clk  input  1  system clock, all logic on its rising edge.
REQ-004 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port cs  input  1  slot select.
REQ-006 SHALL provide port read  input  1  slot read strobe; has no side effects.
REQ-007 SHALL provide port write  input  1  slot write strobe.
REQ-008 SHALL provide port addr  input  5  slot register address; only addr[1:0] decoded.
REQ-009 SHALL provide port wr_data  input  32  slot write data.
REQ-010 SHALL provide port rd_data  output  32  slot read data.
REQ-011 SHALL provide port btn  input  N_BTN  raw asynchronous button levels, active-high.

Function
REQ-012 SHALL pass each btn bit through a 2-flop synchronizer before any other use.
REQ-013 SHALL run one independent debounce FSM per button with states ZERO, WAIT1, ONE, WAIT0 and a down-counter of width clog2(DB_TICKS).
REQ-014 SHALL go ZERO->WAIT1 when synced input is 1, loading counter with DB_TICKS-1.
REQ-015 SHALL, in WAIT1, return to ZERO if synced input is 0, else decrement; at counter 0 with input 1 go to ONE.
REQ-016 SHALL handle ONE->WAIT0->ZERO symmetrically: input 0 loads DB_TICKS-1, input 1 aborts back to ONE.
REQ-017 SHALL drive debounced level bit i = 1 in states ONE and WAIT0, 0 otherwise.
REQ-018 SHALL make debounced level rise at clk edge DB_TICKS+3 after btn goes and stays high; a glitch shorter than DB_TICKS cycles SHALL never change the level.
REQ-019 SHALL set press-capture bit i on the WAIT1->ONE transition and hold it until cleared.
REQ-020 SHALL clear press-capture bit i when cs && write && addr[1:0]==01 && wr_data[i]==1 (write-1-to-clear).
REQ-021 SHALL let set win over clear when both occur for the same bit in the same cycle.
REQ-022 SHALL drive rd_data combinationally from addr[1:0]: 00 debounced levels, 01 press-capture, 10 release-capture (see Configuration), 11 zero; all zero-extended to 32 bits.
REQ-023 SHALL ignore writes to addresses 00, 11 (and 10 when release capture is compiled out).
REQ-024 SHALL ignore cs, read and write for register state except per REQ-020/REQ-032.

Reset
REQ-025 SHALL, on reset, asynchronously force all FSMs to ZERO, counters to 0, synchronizer flops to 0.
REQ-026 SHALL, on reset, clear press-capture and release-capture registers; rd_data reads 0 at every address while reset is held.
REQ-027 SHALL, on reset mid-debounce, discard the pending transition; a button held through reset release is re-qualified from ZERO and captured as a new press.

Configuration
REQ-028 SHALL honour macro BUTTON_INPUT_CORE_RELEASE_CAPTURE_EN.
REQ-029 SHALL, with the macro defined, include an N_BTN-bit release-capture register set on WAIT0->ZERO.
REQ-030 SHALL, with the macro defined, return release-capture at addr 10.
REQ-031 SHALL, without the macro, omit that register and return 0 at addr 10.
REQ-032 SHALL, with the macro defined, clear release-capture by write-1-to-clear at addr 10, set winning over clear.

Verification (DB_TICKS=4, N_BTN=4)
REQ-033 SHALL test: btn=0001 held -> addr00 reads 1 at edge 7 and addr01 reads 1; addr01 stays 1 after btn released.
REQ-034 SHALL test: btn[1] high 3 cycles then low -> addr00 and addr01 stay 0.
REQ-035 SHALL test: press captured, write addr01 wr_data=0x1 -> addr01 reads 0; write 0x2 leaves bit 0 untouched.
REQ-036 SHALL test: clear write in same cycle as WAIT1->ONE of bit 2 -> bit 2 reads 1.
REQ-037 SHALL test: reset asserted during WAIT1 with btn held -> all reads 0, then addr00=1 at edge 7 after reset release.
REQ-038 SHALL test: macro defined, press then release btn[3] -> addr10 reads 0x8; macro undefined -> addr10 reads 0.
